axis_sha3_stream: RTL and testbench

// - Parametrised AXI-Stream front/back end for the Keccak-f[1600] core; supersedes the fixed-mode SHA top.
// - Packs s_axis bytes into rate blocks. Applies SHA3 pad10*1 (domain 0x06) itself.
// - Hands full 1600-bit blocks to the core, then squeezes the digest out on m_axis with TKEEP/TLAST.
// - Runtime mode per message: SHA3-224/256/384/512.

---
 rtl/sha3_pkg.sv | 28 ++
 rtl/sha3_byte_packer.sv | 47 ++++
 rtl/axis_sha3_stream.sv | 168 ++++++++++++++++
 tb/tb_axis_sha3_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types and per-mode constants for the SHA3 AXI-Stream front/back end.
package sha3_pkg;
  typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} sha3_mode_e;
  typedef enum logic [2:0] {IDLE, ABSORB, PAD, SEND, WAIT_DIG, SQUEEZE} axs_state_e;

  localparam int         MAX_RATE    = 144;
  localparam int         MAX_DIG     = 64;
  localparam logic [7:0] DOMAIN_SHA3 = 8'h06;
  localparam logic [7:0] PAD_END     = 8'h80;

  function automatic logic [7:0] rate_bytes(sha3_mode_e m);
    case (m)
      SHA3_224: rate_bytes = 8'd144;
      SHA3_256: rate_bytes = 8'd136;
      SHA3_384: rate_bytes = 8'd104;
      default:  rate_bytes = 8'd72;
    endcase
  endfunction

  function automatic logic [7:0] dig_bytes(sha3_mode_e m);
    case (m)
      SHA3_224: dig_bytes = 8'd28;
      SHA3_256: dig_bytes = 8'd32;
      SHA3_384: dig_bytes = 8'd48;
      default:  dig_bytes = 8'd64;
    endcase
  endfunction
endpackage

// File: rtl/sha3_byte_packer.sv
// Combinational next-value of the rate buffer: drops one stream beat in at the
// byte pointer, or applies the pad10*1 XORs for the current pointer.
module sha3_byte_packer
  import sha3_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [MAX_RATE-1:0][7:0] blk_q,
  input  logic [7:0]               ptr,
  input  logic [7:0]               rate,
  input  logic                     wr_en,
  input  logic [W-1:0][7:0]        wr_data,
  input  logic [W-1:0]             wr_keep,
  input  logic                     pad_en,
  output logic [MAX_RATE-1:0][7:0] blk_d,
  output logic [7:0]               ptr_d
);
  logic [7:0] n;
  logic       run;
  logic [8:0] sum;

  // only the contiguous run of enables from the LSB counts
  always_comb begin
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & wr_keep[i];
      n   = n + {7'd0, run};
    end
  end

  assign sum   = {1'b0, ptr} + {1'b0, n};
  assign ptr_d = (sum > {1'b0, rate}) ? rate : sum[7:0];

  for (genvar j = 0; j < MAX_RATE; j++) begin : g_byte
    logic [7:0] off, b;
    always_comb begin
      off = 8'(j) - ptr;
      b   = blk_q[j];
      for (int i = 0; i < W; i++)
        if (wr_en && off == 8'(i) && 8'(i) < n && 8'(j) < rate) b = wr_data[i];
      if (pad_en && 8'(j) == ptr)          b = b ^ DOMAIN_SHA3;
      if (pad_en && 8'(j) == rate - 8'd1)  b = b ^ PAD_END;
    end
    assign blk_d[j] = b;
  end
endmodule

// File: rtl/axis_sha3_stream.sv
// AXI-Stream wrapper around an external Keccak-f[1600] core: packs and pads
// message bytes into rate blocks, then streams the digest back out.
module axis_sha3_stream
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [1:0]              s_axis_tuser,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [1599:0]           blk_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    blk_last,
  input  logic [1599:0]           dig_data,
  input  logic                    dig_valid,
  output logic                    dig_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [1:0]              m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);
  localparam int W = DATA_WIDTH / 8;

  axs_state_e                state;
  sha3_mode_e                mode;
  logic [ID_WIDTH-1:0]       tid_q;
  logic [MAX_RATE-1:0][7:0]  blk_q, blk_d;
  logic [7:0]                ptr, ptr_d, rate;
  logic                      pad_pend;
  logic [8*MAX_DIG-1:0]      dig_q;
  logic [6:0]                sq_cnt;
  logic [7:0]                byte_off, rem;
  logic [8:0]                bit_off;
  logic                      accept;
  logic                      unused_dig;

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign rate       = rate_bytes(state == IDLE ? sha3_mode_e'(s_axis_tuser) : mode);
  assign unused_dig = ^dig_data[1599:8*MAX_DIG];

  sha3_byte_packer #(.W(W)) u_packer (
    .blk_q   (blk_q),
    .ptr     (ptr),
    .rate    (rate),
    .wr_en   (accept),
    .wr_data (s_axis_tdata),
    .wr_keep (s_axis_tkeep),
    .pad_en  (state == PAD && ptr != rate),
    .blk_d   (blk_d),
    .ptr_d   (ptr_d)
  );

  assign blk_data = {{(1600 - 8*MAX_RATE){1'b0}}, blk_q};

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state         <= IDLE;
      mode          <= SHA3_224;
      tid_q         <= '0;
      blk_q         <= '0;
      ptr           <= '0;
      pad_pend      <= 1'b0;
      dig_q         <= '0;
      sq_cnt        <= '0;
      s_axis_tready <= 1'b0;
      blk_valid     <= 1'b0;
      blk_last      <= 1'b0;
      dig_ready     <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE, ABSORB: begin
          if (state == IDLE) s_axis_tready <= 1'b1;
          if (accept) begin
            blk_q <= blk_d;
            ptr   <= ptr_d;
            if (state == IDLE) begin
              mode  <= sha3_mode_e'(s_axis_tuser);
              tid_q <= s_axis_tid;
            end
            if (s_axis_tlast) begin
              state         <= PAD;
              s_axis_tready <= 1'b0;
            end else if (ptr_d == rate) begin
              state         <= SEND;
              s_axis_tready <= 1'b0;
              blk_valid     <= 1'b1;
              blk_last      <= 1'b0;
            end else begin
              state         <= ABSORB;
              s_axis_tready <= 1'b1;
            end
          end
        end
        PAD: begin
          // a message filling the block exactly still owes a pad-only block
          if (ptr == rate) begin
            pad_pend <= 1'b1;
            blk_last <= 1'b0;
          end else begin
            blk_q    <= blk_d;
            blk_last <= 1'b1;
          end
          blk_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (blk_ready) begin
          blk_valid <= 1'b0;
          blk_q     <= '0;
          ptr       <= '0;
          if (blk_last) begin
            state     <= WAIT_DIG;
            dig_ready <= 1'b1;
          end else if (pad_pend) begin
            state    <= PAD;
            pad_pend <= 1'b0;
          end else begin
            state         <= ABSORB;
            s_axis_tready <= 1'b1;
          end
        end
        WAIT_DIG: if (dig_valid) begin
          dig_q         <= dig_data[8*MAX_DIG-1:0];
          dig_ready     <= 1'b0;
          sq_cnt        <= '0;
          m_axis_tvalid <= 1'b1;
          state         <= SQUEEZE;
        end
        SQUEEZE: if (m_axis_tready) begin
          if (m_axis_tlast) begin
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= IDLE;
          end else begin
            sq_cnt <= sq_cnt + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output beat is a pure function of the held digest and beat index, so it
  // stays stable across back-pressure
  assign byte_off = 8'(sq_cnt) * 8'(W);
  assign bit_off  = 9'(sq_cnt) * 9'(DATA_WIDTH);
  assign rem      = dig_bytes(mode) - byte_off;

  always_comb begin
    m_axis_tdata = dig_q[bit_off +: DATA_WIDTH];
    for (int i = 0; i < W; i++) m_axis_tkeep[i] = 8'(i) < rem;
  end

  assign m_axis_tlast = rem <= 8'(W);
  assign m_axis_tuser = mode;
  assign m_axis_tid   = tid_q;
endmodule

// File: tb/tb_axis_sha3_stream.sv
// Scoreboard bench: reference padding model for blocks, bench-side core
// returning a random digest, expected m_axis beats derived from that digest.
module tb_axis_sha3_stream;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int W  = DW / 8;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic [W-1:0]    s_axis_tkeep = '0;
  logic [1:0]      s_axis_tuser = '0;
  logic [IW-1:0]   s_axis_tid = '0;
  logic            s_axis_tlast = 1'b0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [1599:0]   blk_data;
  logic            blk_valid, blk_last;
  logic            blk_ready = 1'b0;
  logic [1599:0]   dig_data = '0;
  logic            dig_valid = 1'b0;
  logic            dig_ready;
  logic [DW-1:0]   m_axis_tdata;
  logic [W-1:0]    m_axis_tkeep;
  logic [IW-1:0]   m_axis_tid;
  logic [1:0]      m_axis_tuser;
  logic            m_axis_tlast, m_axis_tvalid;
  logic            m_axis_tready = 1'b0;

  always #5 ACLK = ~ACLK;

  axis_sha3_stream #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
    .dig_data(dig_data), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tid(m_axis_tid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  typedef struct { logic [1599:0] data; logic last; } blk_t;
  typedef struct { logic [DW-1:0] data; logic [W-1:0] keep; logic last; logic [IW-1:0] id; logic [1:0] user; } beat_t;

  blk_t         exp_blk[$];
  beat_t        exp_beat[$];
  logic [511:0] dig_pat[$];
  logic [7:0]   msg [0:1023];
  int           RATE [4] = '{144, 136, 104, 72};
  int           DIGB [4] = '{28, 32, 48, 64};
  int           n_vec = 0, n_err = 0, cyc = 0, dig_wait = 0, m_rdy_mode = 0;
  bit           blk_ready_en = 1'b1, blk_rand = 1'b0, dig_took = 1'b0;
  blk_t         cb;
  beat_t        ce;
  logic [DW-1:0] mk;

  task automatic check(string tag, logic [399:0] got, logic [399:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_beat(logic [DW-1:0] d, logic [W-1:0] k, logic l, logic [1:0] u, logic [IW-1:0] id);
    int t = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    s_axis_tuser = u; s_axis_tid = id; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && t < 3000) begin @(negedge ACLK); t++; end
    check("in_accept", 400'(t < 3000), 400'd1);
    @(negedge ACLK);
    s_axis_tvalid = 1'b0;
  endtask

  // pushes the expected blocks/beats, then streams the message in
  task automatic send_msg(int len, int mode, logic [IW-1:0] id, bit gaps);
    int r, d, nb, idx, nbeat, n;
    logic [7:0] v;
    logic [511:0] pat;
    blk_t b;
    beat_t e;
    logic [DW-1:0] dat;
    logic [W-1:0] kp;
    r = RATE[mode]; d = DIGB[mode]; nb = len / r + 1;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int j = 0; j < r; j++) begin
        idx = k * r + j;
        v = (idx < len) ? msg[idx] : 8'h00;
        if (idx == len) v = v ^ 8'h06;
        if (k == nb - 1 && j == r - 1) v = v ^ 8'h80;
        b.data[j*8 +: 8] = v;
      end
      b.last = (k == nb - 1);
      exp_blk.push_back(b);
    end
    for (int i = 0; i < 16; i++) pat[i*32 +: 32] = $urandom;
    dig_pat.push_back(pat);
    nbeat = (d + W - 1) / W;
    for (int k = 0; k < nbeat; k++) begin
      e.data = pat[k*DW +: DW];
      for (int i = 0; i < W; i++) e.keep[i] = (k * W + i < d);
      e.last = (k == nbeat - 1);
      e.id = id;
      e.user = 2'(mode);
      exp_beat.push_back(e);
    end
    if (len == 0) drive_beat('0, '0, 1'b1, 2'(mode), id);
    for (int off = 0; off < len; off += W) begin
      n = (len - off < W) ? len - off : W;
      dat = '0; kp = '0;
      for (int i = 0; i < n; i++) begin dat[i*8 +: 8] = msg[off + i]; kp[i] = 1'b1; end
      // sideband after the first beat is scrambled; only the first beat counts
      if (off == 0) drive_beat(dat, kp, off + n >= len, 2'(mode), id);
      else          drive_beat(dat, kp, off + n >= len, 2'(mode + 1), id + 1'b1);
      if (gaps && $urandom_range(0, 3) == 0) @(negedge ACLK);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_blk.size() != 0 || exp_beat.size() != 0) && t < 5000) begin @(negedge ACLK); t++; end
    check("drain", 400'(t < 5000), 400'd1);
  endtask

  task automatic fill_rand(int len);
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(0, 255));
  endtask

  // bench-side core plus output sink; all sampling on the falling edge
  always @(negedge ACLK) begin
    cyc++;
    blk_ready = blk_rand ? 1'($urandom_range(0, 1)) : blk_ready_en;
    case (m_rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = cyc[0];
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    if (dig_took) begin dig_valid = 1'b0; dig_took = 1'b0; end
    if (ARESETn) begin
      if (blk_valid) begin
        check("in_rdy_send", 400'(s_axis_tready), 400'd0);
        if (blk_ready) begin
          check("blk_expected", 400'(exp_blk.size() != 0), 400'd1);
          if (exp_blk.size() != 0) begin
            cb = exp_blk.pop_front();
            for (int s = 0; s < 4; s++) check($sformatf("blk_data%0d", s), blk_data[s*400 +: 400], cb.data[s*400 +: 400]);
            check("blk_last", 400'(blk_last), 400'(cb.last));
            if (blk_last) dig_wait = 3;
          end
        end
      end
      if (dig_wait > 0) begin
        dig_wait--;
        if (dig_wait == 0 && dig_pat.size() != 0) begin
          for (int i = 0; i < 50; i++) dig_data[i*32 +: 32] = $urandom;
          dig_data[511:0] = dig_pat.pop_front();
          dig_valid = 1'b1;
        end
      end
      if (dig_valid && dig_ready) dig_took = 1'b1;
      if (m_axis_tvalid) begin
        check("beat_expected", 400'(exp_beat.size() != 0), 400'd1);
        if (exp_beat.size() != 0) begin
          ce = exp_beat[0];
          for (int i = 0; i < W; i++) mk[i*8 +: 8] = {8{ce.keep[i]}};
          check("m_tdata", 400'(m_axis_tdata & mk), 400'(ce.data & mk));
          check("m_tkeep", 400'(m_axis_tkeep), 400'(ce.keep));
          check("m_tlast", 400'(m_axis_tlast), 400'(ce.last));
          check("m_tid", 400'(m_axis_tid), 400'(ce.id));
          check("m_tuser", 400'(m_axis_tuser), 400'(ce.user));
          if (m_axis_tready) void'(exp_beat.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge ACLK);
    check("rst_s_tready", 400'(s_axis_tready), 400'd0);
    check("rst_blk_valid", 400'(blk_valid), 400'd0);
    check("rst_dig_ready", 400'(dig_ready), 400'd0);
    check("rst_m_tvalid", 400'(m_axis_tvalid), 400'd0);
    check("rst_blk_data", blk_data[399:0], 400'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    send_msg(0, 1, 2'd1, 0);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 1, 2'd2, 0);
    fill_rand(136); send_msg(135, 1, 2'd3, 0);
    fill_rand(136); send_msg(136, 1, 2'd0, 0);
    drain();

    m_rdy_mode = 1;
    fill_rand(20); send_msg(20, 0, 2'd1, 0);
    drain();
    m_rdy_mode = 0;

    blk_ready_en = 1'b0;
    fill_rand(200);
    fork
      begin repeat (40) @(negedge ACLK); blk_ready_en = 1'b1; end
      send_msg(200, 3, 2'd2, 0);
    join
    drain();

    // reset in the middle of absorbing: that message is dropped
    for (int i = 0; i < 3; i++) drive_beat(64'h0123456789abcdef, '1, 1'b0, 2'd2, 2'd3);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("mid_rst_s_tready", 400'(s_axis_tready), 400'd0);
    check("mid_rst_blk_valid", 400'(blk_valid), 400'd0);
    check("mid_rst_dig_ready", 400'(dig_ready), 400'd0);
    check("mid_rst_m_tvalid", 400'(m_axis_tvalid), 400'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    fill_rand(50); send_msg(50, 2, 2'd1, 0);
    drain();

    m_rdy_mode = 2; blk_rand = 1'b1;
    fill_rand(72);  send_msg(72, 3, 2'd0, 1);
    fill_rand(143); send_msg(143, 0, 2'd1, 1);
    for (int t = 0; t < 12; t++) begin
      int len;
      len = $urandom_range(0, 500);
      fill_rand(len);
      send_msg(len, t % 4, 2'(t), 1);
    end
    drain();
    check("dig_pat_empty", 400'(dig_pat.size()), 400'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
